// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: register block, TX FIFO, baud-timed serializer.
// Drain interrupt fires when the FIFO is empty and the serializer is idle.
module uart_tx_buf #(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] DEF_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq,
    output logic        uart_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [4:0] A_TX_DATA = 5'h00;
    localparam logic [4:0] A_CONTROL = 5'h04;
    localparam logic [4:0] A_DIVIDER = 5'h08;
    localparam logic [4:0] A_STATUS  = 5'h0C;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Registers
    logic [1:0]    ctrl_q;
    logic [15:0]   divider_q;
    logic          ovf_q;

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;

    // Serializer
    logic [1:0]    state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_idx_q;
    logic [15:0]   timer_q;
    logic [15:0]   div_q;
    logic          tx_q;
    logic          irq_q;

    logic tx_en;
    logic irq_en;
    logic full;
    logic empty;
    logic busy;
    logic bit_end;
    logic push_req;
    logic push;
    logic pop;

    assign tx_en    = ctrl_q[0];
    assign irq_en   = ctrl_q[1];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign bit_end  = (timer_q == div_q - 16'd1);
    assign push_req = we && (addr == A_TX_DATA);

    // A pop happens either from IDLE or at the very end of a stop bit,
    // which is what makes back-to-back frames gap-free.
    assign pop  = tx_en && !empty &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    assign push = push_req && (!full || pop);

    // The bus read port has no side effects, and the upper write-data bits
    // have no home in any register.
    logic unused_bits;
    assign unused_bits = ^{re, wd[31:16]};

    // Register block
    always_ff @(posedge clk) begin
        // NOTE: every flop is assigned with <= so all always_ff blocks see
        // the pre-edge values of each other's state.
        if (!rstn) begin
            ctrl_q    <= 2'b00;
            divider_q <= DEF_DIV;
            ovf_q     <= 1'b0;
        end else begin
            if (we && (addr == A_CONTROL)) begin
                ctrl_q <= wd[1:0];
            end
            if (we && (addr == A_DIVIDER)) begin
                divider_q <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
            end
            if (push_req && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (we && (addr == A_STATUS) && wd[9]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; pointers and count
        // define which entries are valid, so stale contents are never read.
        if (push) begin
            mem[wptr_q] <= wd[7:0];
        end
    end

    // FIFO pointers and occupancy; pointer widths make the wrap implicit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Serializer FSM; div_q is captured per frame so DIVIDER writes mid-frame
    // only affect the next frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            timer_q   <= 16'd0;
            div_q     <= DEF_DIV;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= 16'd0;
                    if (pop) begin
                        shift_q <= mem[rptr_q];
                        div_q   <= divider_q;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        timer_q   <= 16'd0;
                        bit_idx_q <= 3'd0;
                        state_q   <= S_DATA;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer_q   <= 16'd0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        timer_q <= 16'd0;
                        if (pop) begin
                            shift_q <= mem[rptr_q];
                            div_q   <= divider_q;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // Line driver and interrupt are both registered so the pins never glitch
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_q  <= 1'b1;
            irq_q <= 1'b0;
        end else begin
            case (state_q)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase
            irq_q <= irq_en && empty && !busy;
        end
    end

    assign uart_tx = tx_q;
    assign irq     = irq_q;

    // Read decode
    always_comb begin
        // NOTE: rd gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rd = 32'h0;
        case (addr)
            A_CONTROL: rd = {30'h0, ctrl_q};
            A_DIVIDER: rd = {16'h0, divider_q};
            A_STATUS:  rd = {22'h0, ovf_q, 5'(count_q), 1'b0, busy, empty, full};
            default:   rd = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: a line monitor decodes frames and checks them
// against a scoreboard filled when bytes are written to TX_DATA.
module tb_uart_tx_buf;

    localparam logic [4:0] A_TX_DATA = 5'h00;
    localparam logic [4:0] A_CONTROL = 5'h04;
    localparam logic [4:0] A_DIVIDER = 5'h08;
    localparam logic [4:0] A_STATUS  = 5'h0C;
    localparam int         DEPTH     = 8;

    logic        clk;
    logic        rstn;
    logic [4:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
    logic        uart_tx;

    uart_tx_buf #(.DEPTH(DEPTH), .DEF_DIV(16'd868)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .addr    (addr),
        .re      (re),
        .we      (we),
        .wd      (wd),
        .rd      (rd),
        .irq     (irq),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb [$];
    int         frame_starts [$];
    int         mon_frames = 0;
    bit         mon_en = 1'b1;
    int         cur_div = 868;

    // Bench-side model of FIFO occupancy and the sticky overflow flag
    int         mcount = 0;
    bit         movf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        re   = 1'b1;
        #1;
        v = rd;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (mcount < DEPTH) begin
            sb.push_back(b);
            mcount++;
        end else begin
            movf = 1'b1;
        end
        bus_write(A_TX_DATA, {24'h0, b});
    endtask

    function automatic logic [31:0] model_status(input logic busy);
        logic [4:0] c;
        c = 5'(mcount);
        return {22'h0, movf, c, 1'b0, busy, (mcount == 0), (mcount == DEPTH)};
    endfunction

    task automatic wait_frames(input int target, input int limit);
        for (int i = 0; i < limit && mon_frames < target; i++) @(negedge clk);
        check("frames_done", mon_frames, target);
    endtask

    // Line monitor: collects 10*cur_div samples per frame, checks every sample
    // of every bit cell, and compares the data byte with the scoreboard head.
    logic       m_samp [0:1023];
    logic [7:0] m_b;
    logic [7:0] m_exp;
    logic       m_mid;
    bit         m_ok;
    int         m_d;
    int         m_start;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rstn === 1'b1 && uart_tx === 1'b0) begin
                m_d       = cur_div;
                m_start   = cyc;
                m_samp[0] = uart_tx;
                for (int i = 1; i < 10 * m_d; i++) begin
                    @(negedge clk);
                    m_samp[i] = uart_tx;
                end
                m_ok = 1'b1;
                m_b  = 8'h00;
                for (int k = 0; k < 10; k++) begin
                    m_mid = m_samp[k * m_d + m_d / 2];
                    for (int j = 0; j < m_d; j++)
                        if (m_samp[k * m_d + j] !== m_mid) m_ok = 1'b0;
                    if (k == 0 && m_mid !== 1'b0) m_ok = 1'b0;
                    if (k == 9 && m_mid !== 1'b1) m_ok = 1'b0;
                    if (k >= 1 && k <= 8) m_b[k - 1] = m_mid;
                end
                check("frame_shape", m_ok, 1'b1);
                check("frame_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    m_exp = sb.pop_front();
                    check("frame_byte", m_b, m_exp);
                end
                frame_starts.push_back(m_start);
                mon_frames++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete, observed time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] v;
    bit          flag;
    int          base;

    initial begin
        rstn = 1'b0;
        addr = 5'h0;
        re   = 1'b0;
        we   = 1'b0;
        wd   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Reset state
        bus_read(A_STATUS, v);   check("rst_status", v, 32'h2);
        bus_read(A_DIVIDER, v);  check("rst_divider", v, 32'd868);
        bus_read(A_CONTROL, v);  check("rst_control", v, 32'h0);
        bus_read(A_TX_DATA, v);  check("txdata_reads_0", v, 32'h0);
        bus_read(5'h10, v);      check("unmapped_reads_0", v, 32'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_uart_tx", uart_tx, 1'b1);

        // Single frame at DIVIDER=4: exact start latency and 40-clock frame
        bus_write(A_DIVIDER, 32'd0);
        bus_read(A_DIVIDER, v);  check("div_zero_as_one", v, 32'd1);
        cur_div = 4;
        bus_write(A_DIVIDER, 32'd4);
        bus_write(A_CONTROL, 32'd1);
        tx_write(8'hA5);
        mcount = 0;
        addr = A_STATUS;
        @(posedge clk); #1;
        check("tx_high_we_p1", uart_tx, 1'b1);
        check("busy_we_p1", rd[2], 1'b1);
        @(posedge clk); #1;
        check("tx_low_we_p2", uart_tx, 1'b0);
        repeat (38) @(posedge clk);
        #1;
        check("busy_at_39", rd[2], 1'b1);
        @(posedge clk); #1;
        check("busy_drop_40", rd[2], 1'b0);
        wait_frames(1, 200);

        // Fill with tx_en=0, overflow, clear, then drain at DIVIDER=2
        bus_write(A_CONTROL, 32'd0);
        cur_div = 2;
        bus_write(A_DIVIDER, 32'd2);
        for (int i = 0; i < 8; i++) tx_write(8'h11 + 8'(i));
        bus_read(A_STATUS, v);   check("status_full", v, model_status(1'b0));
        tx_write(8'h99);
        bus_read(A_STATUS, v);   check("status_overflow", v, model_status(1'b0));
        bus_write(A_STATUS, 32'h200);
        movf = 1'b0;
        bus_read(A_STATUS, v);   check("status_ovf_clear", v, model_status(1'b0));
        base = mon_frames;
        bus_write(A_CONTROL, 32'd1);
        wait_frames(base + 8, 400);
        mcount = 0;
        bus_read(A_STATUS, v);   check("status_drained", v, model_status(1'b0));
        bus_write(A_CONTROL, 32'd0);

        // Three queued bytes, back-to-back at DIVIDER=3
        cur_div = 3;
        bus_write(A_DIVIDER, 32'd3);
        tx_write(8'h3C);
        tx_write(8'hC3);
        tx_write(8'h5A);
        frame_starts.delete();
        base = mon_frames;
        bus_write(A_CONTROL, 32'd1);
        mcount = 0;
        addr = A_STATUS;
        repeat (90) @(posedge clk);
        #1;
        check("b2b_busy_at_89", rd[2], 1'b1);
        @(posedge clk); #1;
        check("b2b_busy_drop_90", rd[2], 1'b0);
        wait_frames(base + 3, 200);
        check("b2b_frame_count", frame_starts.size(), 3);
        if (frame_starts.size() >= 3) begin
            check("b2b_gap_1", frame_starts[1] - frame_starts[0], 30);
            check("b2b_gap_2", frame_starts[2] - frame_starts[1], 30);
        end

        // Interrupt behaviour at DIVIDER=2
        cur_div = 2;
        bus_write(A_DIVIDER, 32'd2);
        bus_write(A_CONTROL, 32'd3);
        @(posedge clk); #1;
        check("irq_idle_empty", irq, 1'b1);
        base = mon_frames;
        tx_write(8'h4B);
        check("irq_still_at_w0", irq, 1'b1);
        @(posedge clk); #1;
        check("irq_drop_w1", irq, 1'b0);
        mcount = 0;
        flag = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (irq !== 1'b0) flag = 1'b0;
        end
        check("irq_low_in_frame", flag, 1'b1);
        @(posedge clk); #1;
        check("irq_after_idle", irq, 1'b1);
        wait_frames(base + 1, 100);

        // Reset in the middle of DATA with two bytes queued
        bus_write(A_CONTROL, 32'd0);
        cur_div = 4;
        bus_write(A_DIVIDER, 32'd4);
        mon_en = 1'b0;
        bus_write(A_TX_DATA, 32'h00);
        bus_write(A_TX_DATA, 32'h7E);
        bus_write(A_CONTROL, 32'd1);
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("tx_low_before_rst", uart_tx, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("tx_high_after_rst", uart_tx, 1'b1);
        addr = A_STATUS;
        #1;
        check("status_after_rst", rd, 32'h2);
        check("irq_after_rst", irq, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        mon_en = 1'b1;
        base = mon_frames;
        bus_read(A_DIVIDER, v);  check("div_after_rst", v, 32'd868);
        flag = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) flag = 1'b0;
        end
        check("no_frames_after_rst", flag, 1'b1);
        check("frame_count_after_rst", mon_frames, base);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
